// File: rtl/rpl_vm_core.sv
// rpl_vm_core: single-engine byte-code VM for compiled RPL patterns.
// It runs instructions from the rplx ROM against the input line buffer.
// A bounded backtrack stack handles choice and call entries.
// Every run ends with a match or no-match result, or with an error code.
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   start            launch a match (accepted only in IDLE)
//   start_pc         first instruction address
//   start_pos        first input position
//   in_len           input length (eof when pos >= in_len)
//   step_limit       instruction budget, 0 = unlimited
//   imem_addr/data   instruction ROM port (data one cycle after addr)
//   in_addr/data     input buffer port (data one cycle after addr)
//   busy, done       run in progress / one-cycle completion pulse
//   matched          result, valid from done until next start
//   match_end        end position on match, else start_pos
//   steps            instructions executed in the current/last run
//   err              0 none, 1 overflow, 2 underflow/kind, 3 budget, 4 opcode
module rpl_vm_core #(
    parameter int PC_W     = 12,
    parameter int POS_W    = 16,
    parameter int BT_DEPTH = 32,
    parameter int STEP_W   = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [PC_W-1:0]   start_pc,
    input  logic [POS_W-1:0]  start_pos,
    input  logic [POS_W-1:0]  in_len,
    input  logic [STEP_W-1:0] step_limit,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [31:0]       imem_data,
    output logic [POS_W-1:0]  in_addr,
    input  logic [7:0]        in_data,
    output logic              busy,
    output logic              done,
    output logic              matched,
    output logic [POS_W-1:0]  match_end,
    output logic [STEP_W-1:0] steps,
    output logic [2:0]        err
);

    localparam int SP_W  = $clog2(BT_DEPTH + 1);
    localparam int IDX_W = (BT_DEPTH > 1) ? $clog2(BT_DEPTH) : 1;

    localparam logic [SP_W-1:0]   SP_ONE   = SP_W'(1);
    localparam logic [SP_W-1:0]   SP_FULL  = SP_W'(BT_DEPTH);
    localparam logic [PC_W-1:0]   PC_ONE   = PC_W'(1);
    localparam logic [POS_W-1:0]  POS_ONE  = POS_W'(1);
    localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);

    localparam logic [4:0] OP_END        = 5'd0;
    localparam logic [4:0] OP_HALT       = 5'd1;
    localparam logic [4:0] OP_CHAR       = 5'd2;
    localparam logic [4:0] OP_ANY        = 5'd3;
    localparam logic [4:0] OP_TEST_CHAR  = 5'd4;
    localparam logic [4:0] OP_TEST_ANY   = 5'd5;
    localparam logic [4:0] OP_JMP        = 5'd6;
    localparam logic [4:0] OP_CHOICE     = 5'd7;
    localparam logic [4:0] OP_COMMIT     = 5'd8;
    localparam logic [4:0] OP_PCOMMIT    = 5'd9;
    localparam logic [4:0] OP_BCOMMIT    = 5'd10;
    localparam logic [4:0] OP_CALL       = 5'd11;
    localparam logic [4:0] OP_RET        = 5'd12;
    localparam logic [4:0] OP_FAIL       = 5'd13;
    localparam logic [4:0] OP_FAIL_TWICE = 5'd14;
    localparam logic [4:0] OP_UNTIL_CHAR = 5'd15;
    localparam logic [4:0] OP_BEHIND     = 5'd16;

    localparam logic [2:0] ERR_NONE   = 3'd0;
    localparam logic [2:0] ERR_OVF    = 3'd1;
    localparam logic [2:0] ERR_UNF    = 3'd2;
    localparam logic [2:0] ERR_BUDGET = 3'd3;
    localparam logic [2:0] ERR_OPCODE = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_UNWIND,
        S_DONE
    } state_t;

    state_t state, state_n;

    logic [PC_W-1:0]   pc, pc_n;
    logic [POS_W-1:0]  pos, pos_n;
    logic [SP_W-1:0]   sp, sp_n;
    logic [STEP_W-1:0] steps_n;
    logic [2:0]        err_n;
    logic              matched_n;
    logic [POS_W-1:0]  match_end_n;

    // Backtrack stack storage; only the pointer needs a reset.
    logic              stk_kind [BT_DEPTH];
    logic [PC_W-1:0]   stk_pc   [BT_DEPTH];
    logic [POS_W-1:0]  stk_pos  [BT_DEPTH];

    logic              push_en;
    logic              push_kind;
    logic [PC_W-1:0]   push_pc;
    logic              tpos_en;
    logic              go_fail;
    logic [2:0]        abort_code;

    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  top_idx;
    logic              top_kind;
    logic [PC_W-1:0]   top_pc;
    logic [POS_W-1:0]  top_pos;

    logic [4:0]        op;
    logic [7:0]        ch;
    logic [PC_W-1:0]   addr;
    logic [POS_W-1:0]  ch_ext;
    logic              eof;
    logic              empty;
    logic              full;
    logic              unused_bits;

    assign op          = imem_data[31:27];
    assign ch          = imem_data[23:16];
    assign addr        = imem_data[PC_W-1:0];
    assign ch_ext      = {{(POS_W-8){1'b0}}, ch};
    assign unused_bits = ^{imem_data[26:24], imem_data[15:0]};

    assign eof   = (pos >= in_len);
    assign empty = (sp == '0);
    assign full  = (sp == SP_FULL);

    // sp-1 wraps when empty; the top entry is only used when not empty.
    assign wr_idx   = IDX_W'(sp);
    assign top_idx  = IDX_W'(sp - SP_ONE);
    assign top_kind = stk_kind[top_idx];
    assign top_pc   = stk_pc[top_idx];
    assign top_pos  = stk_pos[top_idx];

    // The ROM and buffer read the current pc/pos.
    // FETCH presents them, and EXEC sees the returned data.
    assign imem_addr = pc;
    assign in_addr   = pos;
    assign busy      = (state == S_FETCH) || (state == S_EXEC) || (state == S_UNWIND);
    assign done      = (state == S_DONE);

    always_comb begin
        state_n     = state;
        pc_n        = pc;
        pos_n       = pos;
        sp_n        = sp;
        steps_n     = steps;
        err_n       = err;
        matched_n   = matched;
        match_end_n = match_end;
        push_en     = 1'b0;
        push_kind   = 1'b0;
        push_pc     = pc;
        tpos_en     = 1'b0;
        go_fail     = 1'b0;
        abort_code  = ERR_NONE;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n     = S_FETCH;
                    pc_n        = start_pc;
                    pos_n       = start_pos;
                    sp_n        = '0;
                    steps_n     = '0;
                    err_n       = ERR_NONE;
                    matched_n   = 1'b0;
                    match_end_n = start_pos;
                end
            end

            S_FETCH: state_n = S_EXEC;

            S_EXEC: begin
                // The budget is checked before the instruction runs.
                // An instruction blocked by the budget is not counted.
                if ((step_limit != '0) && (steps == step_limit)) begin
                    abort_code = ERR_BUDGET;
                end else begin
                    steps_n = steps + STEP_ONE;
                    state_n = S_FETCH;
                    pc_n    = pc + PC_ONE;
                    case (op)
                        OP_END: begin
                            matched_n   = 1'b1;
                            match_end_n = pos;
                            state_n     = S_DONE;
                        end
                        OP_HALT: begin
                            matched_n = 1'b0;
                            state_n   = S_DONE;
                        end
                        OP_CHAR: begin
                            if (!eof && (in_data == ch)) pos_n = pos + POS_ONE;
                            else go_fail = 1'b1;
                        end
                        OP_ANY: begin
                            if (!eof) pos_n = pos + POS_ONE;
                            else go_fail = 1'b1;
                        end
                        OP_TEST_CHAR: begin
                            if (eof || (in_data != ch)) pc_n = addr;
                        end
                        OP_TEST_ANY: begin
                            if (eof) pc_n = addr;
                        end
                        OP_JMP: pc_n = addr;
                        OP_CHOICE: begin
                            if (full) abort_code = ERR_OVF;
                            else begin
                                push_en   = 1'b1;
                                push_kind = 1'b1;
                                push_pc   = addr;
                                sp_n      = sp + SP_ONE;
                            end
                        end
                        OP_COMMIT: begin
                            if (empty) abort_code = ERR_UNF;
                            else begin
                                sp_n = sp - SP_ONE;
                                pc_n = addr;
                            end
                        end
                        OP_PCOMMIT: begin
                            if (empty) abort_code = ERR_UNF;
                            else begin
                                tpos_en = 1'b1;
                                pc_n    = addr;
                            end
                        end
                        OP_BCOMMIT: begin
                            if (empty) abort_code = ERR_UNF;
                            else begin
                                sp_n  = sp - SP_ONE;
                                pos_n = top_pos;
                                pc_n  = addr;
                            end
                        end
                        OP_CALL: begin
                            if (full) abort_code = ERR_OVF;
                            else begin
                                push_en   = 1'b1;
                                push_kind = 1'b0;
                                push_pc   = pc + PC_ONE;
                                sp_n      = sp + SP_ONE;
                                pc_n      = addr;
                            end
                        end
                        OP_RET: begin
                            if (empty || top_kind) abort_code = ERR_UNF;
                            else begin
                                sp_n = sp - SP_ONE;
                                pc_n = top_pc;
                            end
                        end
                        OP_FAIL: go_fail = 1'b1;
                        OP_FAIL_TWICE: begin
                            if (empty) abort_code = ERR_UNF;
                            else begin
                                sp_n    = sp - SP_ONE;
                                go_fail = 1'b1;
                            end
                        end
                        OP_UNTIL_CHAR: begin
                            // Each skipped byte is a separate FETCH+EXEC at the same pc.
                            if (!eof && (in_data != ch)) begin
                                pos_n = pos + POS_ONE;
                                pc_n  = pc;
                            end
                        end
                        OP_BEHIND: begin
                            if (pos < ch_ext) go_fail = 1'b1;
                            else pos_n = pos - ch_ext;
                        end
                        default: abort_code = ERR_OPCODE;
                    endcase
                end

                if (go_fail) begin
                    state_n = S_UNWIND;
                    pc_n    = pc;
                end
                if (abort_code != ERR_NONE) begin
                    err_n     = abort_code;
                    matched_n = 1'b0;
                    state_n   = S_DONE;
                    push_en   = 1'b0;
                    tpos_en   = 1'b0;
                    sp_n      = sp;
                    pc_n      = pc;
                    pos_n     = pos;
                end
            end

            S_UNWIND: begin
                // An empty stack is an ordinary no-match, not an error.
                if (empty) begin
                    matched_n = 1'b0;
                    state_n   = S_DONE;
                end else begin
                    sp_n = sp - SP_ONE;
                    if (top_kind) begin
                        pc_n    = top_pc;
                        pos_n   = top_pos;
                        state_n = S_FETCH;
                    end
                end
            end

            S_DONE: state_n = S_IDLE;

            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            pc        <= '0;
            pos       <= '0;
            sp        <= '0;
            steps     <= '0;
            err       <= ERR_NONE;
            matched   <= 1'b0;
            match_end <= '0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            pos       <= pos_n;
            sp        <= sp_n;
            steps     <= steps_n;
            err       <= err_n;
            matched   <= matched_n;
            match_end <= match_end_n;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) begin
            stk_kind[wr_idx] <= push_kind;
            stk_pc[wr_idx]   <= push_pc;
            stk_pos[wr_idx]  <= pos;
        end
        if (tpos_en) begin
            stk_pos[top_idx] <= pos;
        end
    end

endmodule

// File: tb/tb_rpl_vm_core.sv
module tb_rpl_vm_core;

    logic        clk;
    logic        rst;
    logic        start;
    logic [11:0] start_pc;
    logic [15:0] start_pos;
    logic [15:0] in_len;
    logic [23:0] step_limit;
    logic [11:0] imem_addr;
    logic [31:0] imem_data;
    logic [15:0] in_addr;
    logic [7:0]  in_data;
    logic        busy;
    logic        done;
    logic        matched;
    logic [15:0] match_end;
    logic [23:0] steps;
    logic [2:0]  err;

    logic [31:0] rom [0:63];
    logic [7:0]  ibuf_mem [0:63];

    int total = 0;
    int bad   = 0;

    rpl_vm_core #(.PC_W(12), .POS_W(16), .BT_DEPTH(4), .STEP_W(24)) dut (
        .clk(clk), .rst(rst), .start(start), .start_pc(start_pc),
        .start_pos(start_pos), .in_len(in_len), .step_limit(step_limit),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .in_addr(in_addr), .in_data(in_data),
        .busy(busy), .done(done), .matched(matched), .match_end(match_end),
        .steps(steps), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM and buffer: data is valid one cycle after the address.
    always @(posedge clk) begin
        imem_data <= rom[imem_addr[5:0]];
        in_data   <= ibuf_mem[in_addr[5:0]];
    end

    function automatic logic [31:0] ins(input logic [4:0] op, input logic [7:0] c,
                                        input logic [11:0] a);
        return {op, 3'b000, c, 4'b0000, a};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) begin
            rom[i]      = ins(5'd1, 8'h00, 12'd0);
            ibuf_mem[i] = 8'h00;
        end
    endtask

    task automatic launch(input logic [11:0] p, input logic [15:0] ps,
                          input logic [15:0] len, input logic [23:0] lim);
        @(posedge clk); #1;
        start_pc = p; start_pos = ps; in_len = len; step_limit = lim;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int bcnt, output bit ok);
        int c;
        bcnt = 0; ok = 1'b0; c = 0;
        while (c < budget && !ok) begin
            if (done) ok = 1'b1;
            else begin
                if (busy) bcnt++;
                @(posedge clk); #1;
                c++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0;
        start_pc = '0; start_pos = '0; in_len = '0; step_limit = '0;
        repeat (3) @(posedge clk);
        #1;
        total++; if ({busy, done, matched} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {busy, done, matched}); end
        total++; if (match_end !== 16'd0 || steps !== 24'd0 || err !== 3'd0) begin bad++; $display("FAIL reset_results got=%0d/%0d/%0d exp=0/0/0", match_end, steps, err); end
        total++; if (imem_addr !== 12'd0 || in_addr !== 16'd0) begin bad++; $display("FAIL reset_addr got=%0d/%0d exp=0/0", imem_addr, in_addr); end
        rst = 1'b0;
    endtask

    task automatic test_seq();
        int bc; bit ok;
        clear_mem();
        ibuf_mem[0] = "a"; ibuf_mem[1] = "b"; ibuf_mem[2] = "c";
        rom[0] = ins(5'd2, "a", 0); rom[1] = ins(5'd2, "b", 0); rom[2] = ins(5'd0, 0, 0);
        launch(12'd0, 16'd0, 16'd3, 24'd0);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL seq_busy_after_start got=%b exp=1", busy); end
        wait_done(200, bc, ok);
        total++; if (!ok) begin bad++; $display("FAIL seq_done got=timeout exp=done"); end
        total++; if (bc !== 6) begin bad++; $display("FAIL seq_busy_cycles got=%0d exp=6", bc); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL seq_busy_in_done got=%b exp=0", busy); end
        total++; if (matched !== 1'b1 || match_end !== 16'd2) begin bad++; $display("FAIL seq_result got=%b/%0d exp=1/2", matched, match_end); end
        total++; if (steps !== 24'd3 || err !== 3'd0) begin bad++; $display("FAIL seq_steps_err got=%0d/%0d exp=3/0", steps, err); end
        @(posedge clk); #1;
        total++; if (done !== 1'b0) begin bad++; $display("FAIL seq_done_one_cycle got=%b exp=0", done); end
    endtask

    task automatic test_backtrack();
        int bc; bit ok;
        clear_mem();
        ibuf_mem[0] = "a"; ibuf_mem[1] = "x";
        rom[0] = ins(5'd7, 0, 12'd4); rom[1] = ins(5'd2, "a", 0); rom[2] = ins(5'd2, "b", 0);
        rom[3] = ins(5'd8, 0, 12'd5); rom[4] = ins(5'd2, "a", 0); rom[5] = ins(5'd0, 0, 0);
        launch(12'd0, 16'd0, 16'd2, 24'd0);
        wait_done(200, bc, ok);
        total++; if (!ok) begin bad++; $display("FAIL bt_done got=timeout exp=done"); end
        total++; if (matched !== 1'b1 || match_end !== 16'd1 || err !== 3'd0) begin bad++; $display("FAIL bt_result got=%b/%0d/%0d exp=1/1/0", matched, match_end, err); end
        total++; if (steps !== 24'd5) begin bad++; $display("FAIL bt_steps got=%0d exp=5", steps); end
    endtask

    task automatic test_until_char();
        int bc; bit ok;
        clear_mem();
        ibuf_mem[0] = "x"; ibuf_mem[1] = "x"; ibuf_mem[2] = "x"; ibuf_mem[3] = "q";
        rom[0] = ins(5'd15, "q", 0); rom[1] = ins(5'd2, "q", 0); rom[2] = ins(5'd0, 0, 0);
        launch(12'd0, 16'd0, 16'd4, 24'd0);
        wait_done(200, bc, ok);
        total++; if (!ok) begin bad++; $display("FAIL until_done got=timeout exp=done"); end
        total++; if (matched !== 1'b1 || match_end !== 16'd4) begin bad++; $display("FAIL until_result got=%b/%0d exp=1/4", matched, match_end); end
        total++; if (steps !== 24'd6 || bc !== 12) begin bad++; $display("FAIL until_steps got=%0d/%0d exp=6/12", steps, bc); end
    endtask

    task automatic test_call_ret();
        int bc; bit ok;
        clear_mem();
        ibuf_mem[0] = "a"; ibuf_mem[1] = "b";
        rom[0] = ins(5'd11, 0, 12'd3); rom[1] = ins(5'd2, "b", 0); rom[2] = ins(5'd0, 0, 0);
        rom[3] = ins(5'd2, "a", 0); rom[4] = ins(5'd12, 0, 0);
        launch(12'd0, 16'd0, 16'd2, 24'd0);
        wait_done(200, bc, ok);
        total++; if (!ok) begin bad++; $display("FAIL call_done got=timeout exp=done"); end
        total++; if (matched !== 1'b1 || match_end !== 16'd2 || steps !== 24'd5) begin bad++; $display("FAIL call_result got=%b/%0d/%0d exp=1/2/5", matched, match_end, steps); end
    endtask

    task automatic test_behind();
        int bc; bit ok;
        clear_mem();
        ibuf_mem[0] = "a"; ibuf_mem[1] = "b";
        rom[0] = ins(5'd16, 8'd1, 0); rom[1] = ins(5'd2, "b", 0); rom[2] = ins(5'd0, 0, 0);
        rom[8] = ins(5'd16, 8'd3, 0); rom[9] = ins(5'd0, 0, 0);
        launch(12'd0, 16'd2, 16'd2, 24'd0);
        wait_done(200, bc, ok);
        total++; if (matched !== 1'b1 || match_end !== 16'd2 || !ok) begin bad++; $display("FAIL behind_ok got=%b/%0d exp=1/2", matched, match_end); end
        launch(12'd8, 16'd2, 16'd2, 24'd0);
        wait_done(200, bc, ok);
        total++; if (matched !== 1'b0 || err !== 3'd0 || match_end !== 16'd2 || !ok) begin bad++; $display("FAIL behind_short got=%b/%0d/%0d exp=0/0/2", matched, err, match_end); end
    endtask

    task automatic test_overflow();
        int bc; bit ok;
        clear_mem();
        rom[0] = ins(5'd7, 0, 12'd0); rom[1] = ins(5'd6, 0, 12'd0);
        launch(12'd0, 16'd0, 16'd0, 24'd0);
        wait_done(200, bc, ok);
        total++; if (!ok || done !== 1'b1) begin bad++; $display("FAIL ovf_done got=%b exp=1", done); end
        total++; if (err !== 3'd1 || matched !== 1'b0 || steps !== 24'd9) begin bad++; $display("FAIL ovf_result got=%0d/%b/%0d exp=1/0/9", err, matched, steps); end
    endtask

    task automatic test_budget();
        int bc; bit ok;
        clear_mem();
        rom[0] = ins(5'd6, 0, 12'd0);
        launch(12'd0, 16'd0, 16'd0, 24'd5);
        wait_done(200, bc, ok);
        total++; if (!ok) begin bad++; $display("FAIL budget_done got=timeout exp=done"); end
        total++; if (err !== 3'd3 || steps !== 24'd5 || matched !== 1'b0) begin bad++; $display("FAIL budget_result got=%0d/%0d/%b exp=3/5/0", err, steps, matched); end
        launch(12'd0, 16'd0, 16'd0, 24'd0);
        repeat (100) @(posedge clk);
        #1;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL unlimited_busy got=%b exp=1", busy); end
        rst = 1'b1;
        @(posedge clk); #1;
        total++; if ({busy, done, matched} !== 3'b000 || err !== 3'd0) begin bad++; $display("FAIL midrst_flags got=%b/%0d exp=000/0", {busy, done, matched}, err); end
        total++; if (match_end !== 16'd0 || steps !== 24'd0 || imem_addr !== 12'd0 || in_addr !== 16'd0) begin bad++; $display("FAIL midrst_values got=%0d/%0d/%0d/%0d exp=0/0/0/0", match_end, steps, imem_addr, in_addr); end
        rst = 1'b0;
    endtask

    task automatic test_errors();
        int bc; bit ok;
        clear_mem();
        rom[0] = ins(5'd7, 0, 12'd5); rom[1] = ins(5'd12, 0, 0);
        rom[10] = ins(5'd31, 0, 0);
        rom[20] = ins(5'd2, "a", 0);
        launch(12'd0, 16'd0, 16'd0, 24'd0);
        wait_done(200, bc, ok);
        total++; if (err !== 3'd2 || matched !== 1'b0 || !ok) begin bad++; $display("FAIL ret_kind got=%0d/%b exp=2/0", err, matched); end
        launch(12'd10, 16'd0, 16'd0, 24'd0);
        wait_done(200, bc, ok);
        total++; if (err !== 3'd4 || matched !== 1'b0 || !ok) begin bad++; $display("FAIL bad_opcode got=%0d/%b exp=4/0", err, matched); end
        launch(12'd20, 16'd3, 16'd0, 24'd0);
        wait_done(200, bc, ok);
        total++; if (matched !== 1'b0 || err !== 3'd0 || match_end !== 16'd3 || !ok) begin bad++; $display("FAIL empty_input got=%b/%0d/%0d exp=0/0/3", matched, err, match_end); end
    endtask

    task automatic test_back_to_back();
        int bc; bit ok;
        clear_mem();
        ibuf_mem[0] = "a"; ibuf_mem[1] = "b";
        rom[0] = ins(5'd2, "a", 0); rom[1] = ins(5'd2, "b", 0); rom[2] = ins(5'd0, 0, 0);
        rom[40] = ins(5'd1, 0, 0);
        launch(12'd0, 16'd0, 16'd2, 24'd0);
        // A start while busy must not redirect the run.
        start_pc = 12'd40; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(200, bc, ok);
        total++; if (!ok || matched !== 1'b1 || match_end !== 16'd2 || steps !== 24'd3) begin bad++; $display("FAIL busy_start got=%b/%0d/%0d exp=1/2/3", matched, match_end, steps); end
        // A start in the DONE cycle is ignored as well.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        total++; if (busy !== 1'b0 || matched !== 1'b1) begin bad++; $display("FAIL done_start got=%b/%b exp=0/1", busy, matched); end
        @(posedge clk); #1;
        total++; if (busy !== 1'b0 || match_end !== 16'd2) begin bad++; $display("FAIL result_hold got=%b/%0d exp=0/2", busy, match_end); end
    endtask

    initial begin
        clear_mem();
        test_reset();
        test_seq();
        test_backtrack();
        test_until_char();
        test_call_ret();
        test_behind();
        test_overflow();
        test_budget();
        test_errors();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
